// File: rtl/trace_buffer.sv
// trace_buffer: commit-trace capture buffer for post-mortem debug of the core.
//
// Records one snapshot per committed instruction into a circular buffer.
// While ARMED it keeps the most recent Depth records as pre-trigger history.
// A PC match fires the trigger, and PostTrigger further commits are captured
// in POST. The buffer then freezes in DONE and drains oldest-first over a
// valid/ready port. After the last record is read it returns to IDLE.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   arm, disarm                   start capture (IDLE only) / abort to IDLE
//   trigger_enable, trigger_pc    PC-match trigger control
//   commit_valid, pc, instr, write_back, alu_result, reg_write, memory_write
//                                 commit record input
//   rd_valid, rd_ready, rd_*      readout handshake and record fields
//   state                         00 IDLE, 01 ARMED, 10 POST, 11 DONE
//   count                         valid entries held (0..Depth)
//   triggered, overflow           sticky status, cleared on arm
module trace_buffer #(
  parameter int RegBits     = 32,
  parameter int Depth       = 16,
  parameter int PostTrigger = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   disarm,
  input  logic                   trigger_enable,
  input  logic [RegBits-1:0]     trigger_pc,
  input  logic                   commit_valid,
  input  logic [RegBits-1:0]     pc,
  input  logic [RegBits-1:0]     instr,
  input  logic [RegBits-1:0]     write_back,
  input  logic [RegBits-1:0]     alu_result,
  input  logic                   reg_write,
  input  logic                   memory_write,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [RegBits-1:0]     rd_pc,
  output logic [RegBits-1:0]     rd_instr,
  output logic [RegBits-1:0]     rd_write_back,
  output logic [RegBits-1:0]     rd_alu_result,
  output logic                   rd_reg_write,
  output logic                   rd_memory_write,
  output logic [1:0]             state,
  output logic [$clog2(Depth):0] count,
  output logic                   triggered,
  output logic                   overflow
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam int RecW = 4 * RegBits + 2;
  localparam logic [CntW-1:0] Full     = CntW'(Depth);
  localparam logic [PtrW-1:0] PostInit = PtrW'(PostTrigger);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          state_reg, state_next;
  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PtrW-1:0] post_cnt_reg, post_cnt_next;
  logic [CntW-1:0] count_reg, count_next;
  logic            triggered_reg, triggered_next;
  logic            overflow_reg, overflow_next;
  logic            wr_en;
  logic [RecW-1:0] wr_rec;
  logic [RecW-1:0] rd_rec;

  // Record storage; contents are deliberately not reset.
  logic [RecW-1:0] mem [Depth];

  assign wr_rec = {pc, instr, write_back, alu_result, reg_write, memory_write};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_rec;
    end
  end

  assign rd_rec   = mem[rd_ptr_reg];
  assign rd_valid = (state_reg == S_DONE) && (count_reg != '0);

  // Fields are forced to zero whenever no record is presented.
  assign rd_pc           = rd_valid ? rd_rec[RecW-1 -: RegBits]             : '0;
  assign rd_instr        = rd_valid ? rd_rec[3*RegBits+1 -: RegBits]       : '0;
  assign rd_write_back   = rd_valid ? rd_rec[2*RegBits+1 -: RegBits]       : '0;
  assign rd_alu_result   = rd_valid ? rd_rec[RegBits+1 -: RegBits]         : '0;
  assign rd_reg_write    = rd_valid ? rd_rec[1]                            : 1'b0;
  assign rd_memory_write = rd_valid ? rd_rec[0]                            : 1'b0;

  assign state     = state_reg;
  assign count     = count_reg;
  assign triggered = triggered_reg;
  assign overflow  = overflow_reg;

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    post_cnt_next  = post_cnt_reg;
    count_next     = count_reg;
    triggered_next = triggered_reg;
    overflow_next  = overflow_reg;
    wr_en          = 1'b0;

    if (disarm) begin
      state_next = S_IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (arm) begin
            state_next     = S_ARMED;
            wr_ptr_next    = '0;
            count_next     = '0;
            triggered_next = 1'b0;
            overflow_next  = 1'b0;
          end
        end

        S_ARMED, S_POST: begin
          if (commit_valid) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            // A full buffer keeps its count; the write replaces the oldest.
            if (count_reg == Full) begin
              overflow_next = 1'b1;
            end else begin
              count_next = count_reg + 1'b1;
            end

            if (state_reg == S_ARMED) begin
              if (trigger_enable && (pc == trigger_pc)) begin
                triggered_next = 1'b1;
                if (PostTrigger == 0) begin
                  state_next = S_DONE;
                end else begin
                  state_next    = S_POST;
                  post_cnt_next = PostInit;
                end
              end
            end else begin
              post_cnt_next = post_cnt_reg - 1'b1;
              if (post_cnt_reg == PtrW'(1)) begin
                state_next = S_DONE;
              end
            end

            // Oldest entry, computed from the post-write pointer and count.
            // When full, the low count bits are zero and oldest == wr_ptr.
            if (state_next == S_DONE) begin
              rd_ptr_next = wr_ptr_next - count_next[PtrW-1:0];
            end
          end
        end

        S_DONE: begin
          if (rd_valid && rd_ready) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
            count_next  = count_reg - 1'b1;
            if (count_reg == CntW'(1)) begin
              state_next = S_IDLE;
            end
          end
        end

        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      post_cnt_reg  <= '0;
      count_reg     <= '0;
      triggered_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      post_cnt_reg  <= post_cnt_next;
      count_reg     <= count_next;
      triggered_reg <= triggered_next;
      overflow_reg  <= overflow_next;
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;

  logic        clk;
  logic        rst;
  logic        arm, arm0, disarm, trigger_enable;
  logic [31:0] trigger_pc;
  logic        commit_valid;
  logic [31:0] pc, instr, write_back, alu_result;
  logic        reg_write, memory_write;
  logic        rd_ready;

  // Main instance: Depth 16, PostTrigger 8.
  logic        rd_valid;
  logic [31:0] rd_pc, rd_instr, rd_write_back, rd_alu_result;
  logic        rd_reg_write, rd_memory_write;
  logic [1:0]  state;
  logic [4:0]  count;
  logic        triggered, overflow;

  // Second instance: PostTrigger 0, armed separately.
  logic        rd_valid0;
  logic [31:0] rd_pc0, rd_instr0, rd_write_back0, rd_alu_result0;
  logic        rd_reg_write0, rd_memory_write0;
  logic [1:0]  state0;
  logic [4:0]  count0;
  logic        triggered0, overflow0;

  int tests_run = 0;
  int tests_failed = 0;

  trace_buffer #(.RegBits(32), .Depth(16), .PostTrigger(8)) u_dut (
    .clk(clk), .rst(rst), .arm(arm), .disarm(disarm),
    .trigger_enable(trigger_enable), .trigger_pc(trigger_pc),
    .commit_valid(commit_valid), .pc(pc), .instr(instr),
    .write_back(write_back), .alu_result(alu_result),
    .reg_write(reg_write), .memory_write(memory_write),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .rd_write_back(rd_write_back),
    .rd_alu_result(rd_alu_result), .rd_reg_write(rd_reg_write),
    .rd_memory_write(rd_memory_write), .state(state), .count(count),
    .triggered(triggered), .overflow(overflow)
  );

  trace_buffer #(.RegBits(32), .Depth(16), .PostTrigger(0)) u_dut0 (
    .clk(clk), .rst(rst), .arm(arm0), .disarm(disarm),
    .trigger_enable(trigger_enable), .trigger_pc(trigger_pc),
    .commit_valid(commit_valid), .pc(pc), .instr(instr),
    .write_back(write_back), .alu_result(alu_result),
    .reg_write(reg_write), .memory_write(memory_write),
    .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_pc(rd_pc0),
    .rd_instr(rd_instr0), .rd_write_back(rd_write_back0),
    .rd_alu_result(rd_alu_result0), .rd_reg_write(rd_reg_write0),
    .rd_memory_write(rd_memory_write0), .state(state0), .count(count0),
    .triggered(triggered0), .overflow(overflow0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Record fields derived from pc so readout can be predicted independently.
  function automatic logic [31:0] f_instr(input logic [31:0] p);
    return p ^ 32'h0000_0013;
  endfunction
  function automatic logic [31:0] f_wb(input logic [31:0] p);
    return p + 32'h1000;
  endfunction
  function automatic logic [31:0] f_alu(input logic [31:0] p);
    return ~p;
  endfunction
  function automatic logic f_rw(input logic [31:0] p);
    return ^p[11:0];
  endfunction
  function automatic logic f_mw(input logic [31:0] p);
    return p[3];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_commit(input logic [31:0] p);
    commit_valid = 1'b1;
    pc           = p;
    instr        = f_instr(p);
    write_back   = f_wb(p);
    alu_result   = f_alu(p);
    reg_write    = f_rw(p);
    memory_write = f_mw(p);
    tick();
    commit_valid = 1'b0;
    $display("[TB] commit pc=%08h state=%0d count=%0d", p, state, count);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Reads n records with rd_ready held high, expecting pc = first_pc + 4*i.
  task automatic drain(input int n, input logic [31:0] first_pc);
    logic [31:0] ep;
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      ep = first_pc + 32'(4 * i);
      chk("drain_valid", 64'(rd_valid), 64'd1);
      chk("drain_pc", 64'(rd_pc), 64'(ep));
      chk("drain_instr", 64'(rd_instr), 64'(f_instr(ep)));
      chk("drain_rw", 64'(rd_reg_write), 64'(f_rw(ep)));
      $display("[TB] read pc=%08h expected=%08h", rd_pc, ep);
      tick();
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; arm0 = 1'b0; disarm = 1'b0;
    trigger_enable = 1'b0; trigger_pc = '0; commit_valid = 1'b0;
    pc = '0; instr = '0; write_back = '0; alu_result = '0;
    reg_write = 1'b0; memory_write = 1'b0; rd_ready = 1'b0;

    // Reset state
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_pc", 64'(rd_pc), 64'd0);
    chk("rst_trig", 64'(triggered), 64'd0);
    rst = 1'b0;
    tick();

    // Basic capture: trigger on the 3rd commit, 8 post entries -> 11 held.
    trigger_enable = 1'b1;
    trigger_pc     = 32'h08;
    pulse_arm();
    chk("arm_state", 64'(state), 64'd1);
    for (int i = 0; i < 3; i++) do_commit(32'(4 * i));
    chk("trig_state", 64'(state), 64'd2);
    chk("trig_flag", 64'(triggered), 64'd1);
    for (int i = 3; i < 10; i++) do_commit(32'(4 * i));
    chk("post_state", 64'(state), 64'd2);
    do_commit(32'(4 * 10));
    chk("done_state", 64'(state), 64'd3);
    chk("done_count", 64'(count), 64'd11);
    chk("done_ovf", 64'(overflow), 64'd0);

    // Backpressure: record held stable while not accepted.
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rd_valid), 64'd1);
      chk("bp_pc", 64'(rd_pc), 64'd0);
      chk("bp_alu", 64'(rd_alu_result), 64'(f_alu(32'd0)));
      chk("bp_count", 64'(count), 64'd11);
      tick();
    end
    drain(11, 32'h0);
    chk("drained_state", 64'(state), 64'd0);
    chk("drained_valid", 64'(rd_valid), 64'd0);
    chk("drained_trig", 64'(triggered), 64'd1);

    // Wrap: trigger at i=30, DONE after i=38, oldest kept is i=23.
    trigger_pc = 32'(4 * 30);
    pulse_arm();
    chk("wrap_trig_clr", 64'(triggered), 64'd0);
    for (int i = 0; i < 40; i++) do_commit(32'(4 * i));
    chk("wrap_state", 64'(state), 64'd3);
    chk("wrap_count", 64'(count), 64'd16);
    chk("wrap_ovf", 64'(overflow), 64'd1);
    drain(16, 32'h5C);
    chk("wrap_idle", 64'(state), 64'd0);
    chk("wrap_ovf_kept", 64'(overflow), 64'd1);

    // PostTrigger = 0: trigger on first commit goes straight to DONE.
    trigger_pc = 32'h100;
    arm0 = 1'b1;
    tick();
    arm0 = 1'b0;
    chk("pt0_armed", 64'(state0), 64'd1);
    do_commit(32'h100);
    chk("pt0_state", 64'(state0), 64'd3);
    chk("pt0_count", 64'(count0), 64'd1);
    chk("pt0_pc", 64'(rd_pc0), 64'h100);
    chk("pt0_rw", 64'(rd_reg_write0), 64'd1);
    chk("pt0_main_idle", 64'(count), 64'd0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("pt0_idle", 64'(state0), 64'd0);

    // arm together with disarm in IDLE stays IDLE.
    arm = 1'b1; disarm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0;
    chk("armdis_state", 64'(state), 64'd0);

    // disarm during ARMED with 7 entries.
    trigger_enable = 1'b0;
    pulse_arm();
    for (int i = 0; i < 7; i++) do_commit(32'h200 + 32'(4 * i));
    chk("pre_dis_count", 64'(count), 64'd7);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    chk("dis_state", 64'(state), 64'd0);
    chk("dis_count", 64'(count), 64'd0);
    do_commit(32'h300);
    chk("dis_ignored", 64'(count), 64'd0);

    // Asynchronous reset mid-POST, checked between clock edges.
    trigger_enable = 1'b1;
    trigger_pc     = 32'h0;
    pulse_arm();
    do_commit(32'h0);
    do_commit(32'h4);
    chk("mid_post", 64'(state), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(rd_valid), 64'd0);
    chk("arst_trig", 64'(triggered), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
